// File: rtl/jisuan_sched.sv
// jisuan_sched: two-requester round-robin front end for one shared ChaCha/Salsa
// round core. It takes one job at a time, issues it to the core, and returns
// the core result on the owning requester's response channel.
// Optional feature macro: JISUAN_SCHED_STAT_EN adds the grant_cnt0/grant_cnt1
// saturating accept counters.
module jisuan_sched #(
  parameter int DW    = 512,
  parameter int CNT_W = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          r0_vld,
  output logic          r0_rdy,
  input  logic [DW-1:0] r0_cha,
  input  logic [DW-1:0] r0_sha,
  input  logic          r1_vld,
  output logic          r1_rdy,
  input  logic [DW-1:0] r1_cha,
  input  logic [DW-1:0] r1_sha,
  output logic          d0_vld,
  input  logic          d0_rdy,
  output logic          d1_vld,
  input  logic          d1_rdy,
  output logic [DW-1:0] d_cha,
  output logic [DW-1:0] d_sha,
  output logic          core_in_vld,
  input  logic          core_in_rdy,
  output logic [DW-1:0] core_cha,
  output logic [DW-1:0] core_sha,
  input  logic          core_out_vld,
  output logic          core_out_rdy,
  input  logic [DW-1:0] core_res_cha,
  input  logic [DW-1:0] core_res_sha,
  output logic          busy,
  output logic          owner
`ifdef JISUAN_SCHED_STAT_EN
  ,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state_reg;
  state_t        state_next;
  logic          owner_reg;
  logic          last_reg;
  logic [DW-1:0] hold_cha_reg;
  logic [DW-1:0] hold_sha_reg;
  logic [DW-1:0] d_cha_reg;
  logic [DW-1:0] d_sha_reg;

  logic          grant0;
  logic          grant1;
  logic          accept0;
  logic          accept1;
  logic          cap_res;

  // Round-robin grant in IDLE, handshake outputs and next-state decode.
  always_comb begin
    state_next   = state_reg;
    grant0       = 1'b0;
    grant1       = 1'b0;
    r0_rdy       = 1'b0;
    r1_rdy       = 1'b0;
    accept0      = 1'b0;
    accept1      = 1'b0;
    core_in_vld  = 1'b0;
    core_out_rdy = 1'b0;
    cap_res      = 1'b0;
    d0_vld       = 1'b0;
    d1_vld       = 1'b0;
    case (state_reg)
      IDLE: begin
        // On a tie the requester that was not granted last time wins.
        grant0  = r0_vld & (~r1_vld | last_reg);
        grant1  = r1_vld & (~r0_vld | ~last_reg);
        r0_rdy  = grant0 & ~rst;
        r1_rdy  = grant1 & ~rst;
        accept0 = r0_vld & r0_rdy;
        accept1 = r1_vld & r1_rdy;
        if (accept0 | accept1) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        core_in_vld = 1'b1;
        if (core_in_rdy) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        // core_out_vld is only honoured here; anything else is stray.
        core_out_rdy = 1'b1;
        cap_res      = core_out_vld;
        if (core_out_vld) begin
          state_next = RESP;
        end
      end
      RESP: begin
        d0_vld = ~owner_reg;
        d1_vld = owner_reg;
        if (owner_reg ? d1_rdy : d0_rdy) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Control state: FSM register, job owner and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      owner_reg <= 1'b0;
      last_reg  <= 1'b1;
    end else begin
      state_reg <= state_next;
      if (accept0) begin
        owner_reg <= 1'b0;
        last_reg  <= 1'b0;
      end else if (accept1) begin
        owner_reg <= 1'b1;
        last_reg  <= 1'b1;
      end
    end
  end

  // Job and result data; no reset, they are only qualified by the FSM state.
  always_ff @(posedge clk) begin
    if (accept0) begin
      hold_cha_reg <= r0_cha;
      hold_sha_reg <= r0_sha;
    end else if (accept1) begin
      hold_cha_reg <= r1_cha;
      hold_sha_reg <= r1_sha;
    end
    if (cap_res) begin
      d_cha_reg <= core_res_cha;
      d_sha_reg <= core_res_sha;
    end
  end

  assign core_cha = hold_cha_reg;
  assign core_sha = hold_sha_reg;
  assign d_cha    = d_cha_reg;
  assign d_sha    = d_sha_reg;
  assign busy     = (state_reg != IDLE);
  assign owner    = owner_reg;

`ifdef JISUAN_SCHED_STAT_EN
  logic [1:0] accept_vec;
  assign accept_vec = {accept1, accept0};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_reg;
      // Per-requester accept counter, saturating at all-ones.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_reg <= '0;
        end else if (accept_vec[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end
    end
  endgenerate

  assign grant_cnt0 = g_cnt[0].cnt_reg;
  assign grant_cnt1 = g_cnt[1].cnt_reg;
`endif

endmodule
